comp_engine_arbiter: RTL and testbench
======================================

// Module: comp_engine_arbiter
// PURPOSE
//  Shares one compress/decompress engine between two requesters.
//  Arbitrates round-robin and latches the winning request.
//  Issues a one-cycle command to the engine and waits for its response, bounded by a timeout.
//  Returns the result to the granted requester. Sits between client logic and the comp_if engine port.
// PARAMETERS
//  DATA_WIDTH  8   compressed code width; matches engine compressed_in/out
//  TIMEOUT     16  max WAIT cycles without engine response before recovery (>=2)
// PORTS
//  clk                input   1            clock; all logic on posedge
//  reset              input   1            synchronous, active-low reset
//  req_valid          input   2            per-requester request valid; held until req_ready
//  req_cmd            input   4            req i command at [2i+:2]: 01 compress, 10 decompress, 00/11 illegal
//  req_data           input   160          req i 80-bit plain data at [80i+:80]
//  req_code           input   2*DATA_WIDTH req i code at [DATA_WIDTH*i+:DATA_WIDTH]
//  req_ready          output  2            one-hot accept; request taken at edge where valid&ready
//  rsp_valid          output  2            one-hot, one-cycle result pulse to the granted requester
//  rsp_resp           output  2            00 none, 01 ok, 10 engine error, 11 controller error
//  rsp_code           output  DATA_WIDTH   captured engine compressed_out
//  rsp_data           output  80           captured engine decompressed_out
//  busy               output  1            state != IDLE
//  eng_command        output  2            engine command; non-zero for exactly one cycle per transaction
//  eng_data_in        output  80           latched req_data of the granted requester
//  eng_compressed_in  output  DATA_WIDTH   latched req_code of the granted requester
//  eng_compressed_out input   DATA_WIDTH   engine code result
//  eng_decompressed_out input 80           engine data result
//  eng_response       input   2            engine response; 00 means none yet
//  eng_reset          output  1            active-low engine reset
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state IDLE, prio=0, counter=0.
//   - All outputs 0 except eng_reset, which is 0 while reset is low.
//   - An in-flight transaction is abandoned with no rsp_valid.
//  FSM states: IDLE, ISSUE, WAIT, RECOVER, DONE.
//  IDLE:
//   - req_ready is combinational and goes to the winner g.
//   - If both requesters are valid, g=prio; otherwise g is the single valid requester.
//   - On accept, latch cmd/data/code/g and set prio=~g.
//   - Legal cmd -> ISSUE. Illegal cmd (00/11) -> DONE with resp 11; engine is untouched.
//  ISSUE (1 cycle):
//   - eng_command = latched cmd; counter=0; -> WAIT.
//  WAIT:
//   - eng_command=00.
//   - If eng_response!=00: capture resp/code/data -> DONE.
//   - Otherwise counter++. When counter reaches TIMEOUT-1 with no response -> RECOVER.
//   - A response arriving in the terminal-count cycle wins over the timeout.
//  RECOVER (1 cycle):
//   - eng_reset=0; resp=11; code=0; data=0 -> DONE.
//  DONE (1 cycle):
//   - rsp_valid[g]=1 with the captured rsp_resp/code/data -> IDLE.
//   - rsp_* are 0 whenever rsp_valid==0.
//  Outputs and ignored inputs:
//   - eng_data_in and eng_compressed_in hold their latched values until the next accept.
//   - eng_response outside WAIT is ignored.
//   - req_ready is 0 outside IDLE; requesters hold their requests.
//  Latency:
//   - Handshake edge T; ISSUE at T+1; earliest WAIT sample at T+2.
//   - Earliest rsp_valid at T+3, i.e. engine response one cycle after the command.
//   - Illegal cmd: rsp_valid at T+1.
//  Throughput: at most one transaction in flight; the next accept is possible in the cycle after DONE.
// TESTING
//  1. req0 cmd 01, data 80'h0123_4567_89AB_CDEF_0011; engine returns 01, code 8'h2A in the 1st WAIT cycle
//     -> req_ready[0] one cycle; eng_command=01 one cycle; rsp_valid[0] at T+3 with resp 01, code 2A.
//  2. Both requesters valid continuously with cmd 01 after reset; engine answers immediately
//     -> grants alternate 0,1,0,1; rsp_valid one-hot follows the grant.
//  3. req1 cmd 11 -> accepted; eng_command stays 00; rsp_valid[1] at T+1 with resp 11.
//  4. req0 cmd 10, code 8'h05; engine silent
//     -> after 16 WAIT cycles, eng_reset=0 for one cycle; rsp_valid[0] with resp 11, data 0.
//     -> A following req1 cmd 01 completes normally.
//  5. reset=0 for one cycle during WAIT
//     -> no rsp_valid; eng_reset=0 that cycle; busy=0; the next request with both valid goes to req0.
//  6. Engine returns 10 (e.g. unknown code) together with the 16th WAIT cycle -> rsp resp 10; no RECOVER.

Source files
------------

// File: rtl/comp_engine_arbiter.sv
// rtl/comp_engine_arbiter.sv - round-robin arbiter sharing one compress/decompress engine between two requesters
// A single transaction is in flight at a time; an engine that stays silent is reset and answered with a controller error.
module comp_engine_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [3:0]              req_cmd,
  input  logic [159:0]            req_data,
  input  logic [2*DATA_WIDTH-1:0] req_code,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [1:0]              rsp_resp,
  output logic [DATA_WIDTH-1:0]   rsp_code,
  output logic [79:0]             rsp_data,
  output logic                    busy,
  output logic [1:0]              eng_command,
  output logic [79:0]             eng_data_in,
  output logic [DATA_WIDTH-1:0]   eng_compressed_in,
  input  logic [DATA_WIDTH-1:0]   eng_compressed_out,
  input  logic [79:0]             eng_decompressed_out,
  input  logic [1:0]              eng_response,
  output logic                    eng_reset
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] RESP_CTRL_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    prio_q, prio_d;
  logic                    gnt_q, gnt_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [79:0]             data_q, data_d;
  logic [DATA_WIDTH-1:0]   code_q, code_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rcode_q, rcode_d;
  logic [79:0]             rdata_q, rdata_d;

  logic                    win_valid;
  logic                    win;
  logic [1:0]              win_cmd;
  logic [79:0]             win_data;
  logic [DATA_WIDTH-1:0]   win_code;

  // Both valid: the priority pointer decides; otherwise the lone requester wins.
  always_comb begin
    win_valid = |req_valid;
    win       = (req_valid == 2'b11) ? prio_q : req_valid[1];
    win_cmd   = win ? req_cmd[3:2] : req_cmd[1:0];
    win_data  = win ? req_data[159:80] : req_data[79:0];
    win_code  = win ? req_code[2*DATA_WIDTH-1:DATA_WIDTH] : req_code[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    code_d  = code_q;
    resp_d  = resp_q;
    rcode_d = rcode_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          gnt_d  = win;
          prio_d = ~win;
          cmd_d  = win_cmd;
          data_d = win_data;
          code_d = win_code;
          if (^win_cmd) begin
            state_d = S_ISSUE;
          end else begin
            resp_d  = RESP_CTRL_ERR;
            rcode_d = '0;
            rdata_d = '0;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response in the terminal-count cycle still beats the timeout.
        if (eng_response != 2'b00) begin
          resp_d  = eng_response;
          rcode_d = eng_compressed_out;
          rdata_d = eng_decompressed_out;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        resp_d  = RESP_CTRL_ERR;
        rcode_d = '0;
        rdata_d = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      code_q  <= '0;
      resp_q  <= '0;
      rcode_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      code_q  <= code_d;
      resp_q  <= resp_d;
      rcode_q <= rcode_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    req_ready         = 2'b00;
    rsp_valid         = 2'b00;
    rsp_resp          = 2'b00;
    rsp_code          = '0;
    rsp_data          = '0;
    eng_command       = 2'b00;
    busy              = (state_q != S_IDLE);
    eng_data_in       = data_q;
    eng_compressed_in = code_q;
    eng_reset         = reset && (state_q != S_RECOVER);

    if (state_q == S_IDLE && reset && win_valid) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
    if (state_q == S_ISSUE) begin
      eng_command = cmd_q;
    end
    if (state_q == S_DONE) begin
      rsp_valid = gnt_q ? 2'b10 : 2'b01;
      rsp_resp  = resp_q;
      rsp_code  = rcode_q;
      rsp_data  = rdata_q;
    end
  end

endmodule

// File: tb/tb_comp_engine_arbiter.sv
// tb/tb_comp_engine_arbiter.sv - self-checking bench for comp_engine_arbiter
module tb_comp_engine_arbiter;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [3:0]    req_cmd;
  logic [159:0]  req_data;
  logic [2*DW-1:0] req_code;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_code;
  logic [79:0]   rsp_data;
  logic          busy;
  logic [1:0]    eng_command;
  logic [79:0]   eng_data_in;
  logic [DW-1:0] eng_compressed_in;
  logic [DW-1:0] eng_compressed_out;
  logic [79:0]   eng_decompressed_out;
  logic [1:0]    eng_response;
  logic          eng_reset;

  always #5 clk = ~clk;

  comp_engine_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_data(req_data), .req_code(req_code),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_code(rsp_code), .rsp_data(rsp_data),
    .busy(busy), .eng_command(eng_command), .eng_data_in(eng_data_in),
    .eng_compressed_in(eng_compressed_in), .eng_compressed_out(eng_compressed_out),
    .eng_decompressed_out(eng_decompressed_out), .eng_response(eng_response),
    .eng_reset(eng_reset)
  );

  // k = WAIT cycle (1..TO) in which the engine answers; 0 = engine stays silent
  typedef struct {
    logic [1:0]    cmd;
    logic [79:0]   data;
    logic [DW-1:0] code;
    int            k;
    logic [1:0]    eresp;
    logic [DW-1:0] ecode;
    logic [79:0]   edata;
    bit            junk;
  } req_t;

  req_t q0[$];
  req_t q1[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  bit            m_active = 0;
  int            m_c = 0;
  bit            m_g = 0;
  req_t          m_e;
  bit            m_prio = 0;
  logic [79:0]   m_ldata = '0;
  logic [DW-1:0] m_lcode = '0;
  bit            pop0 = 0;
  bit            pop1 = 0;

  int            ev_cyc[$];
  logic [1:0]    ev_g[$];
  logic [1:0]    ev_resp[$];
  logic [DW-1:0] ev_code[$];
  logic [79:0]   ev_data[$];
  int            acc_cyc[$];

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int winner(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 1 : 0;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  function automatic req_t mk(input logic [1:0] cmd, input logic [79:0] data, input logic [DW-1:0] code,
                              input int k, input logic [1:0] eresp, input logic [DW-1:0] ecode,
                              input logic [79:0] edata, input bit junk);
    req_t r;
    r.cmd = cmd; r.data = data; r.code = code; r.k = k;
    r.eresp = eresp; r.ecode = ecode; r.edata = edata; r.junk = junk;
    return r;
  endfunction

  function automatic bit is_legal(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  // Cycle offset (from the accept cycle) at which the result pulse must appear.
  function automatic int done_off(input req_t e);
    if (!is_legal(e.cmd)) return 1;
    if (e.k != 0) return 1 + 1 + e.k;
    return 1 + TO + 1 + 1;
  endfunction

  // Model and compare: every negedge, derive each output from the transaction timeline.
  always @(negedge clk) begin
    logic [1:0]    x_ready, x_cmd, x_rv, x_resp;
    logic [DW-1:0] x_code;
    logic [79:0]   x_data;
    logic          x_busy, x_erst;
    int            w, d, dd;
    bit            legal;

    if (rsp_valid != 2'b00) begin
      ev_cyc.push_back(cyc); ev_g.push_back(rsp_valid); ev_resp.push_back(rsp_resp);
      ev_code.push_back(rsp_code); ev_data.push_back(rsp_data);
    end
    if ((req_valid & req_ready) != 2'b00) acc_cyc.push_back(cyc);

    if (!reset) begin
      chk("eng_reset_during_reset", {79'd0, eng_reset}, 80'd0);
      m_active = 0; m_prio = 0; m_ldata = '0; m_lcode = '0;
    end else begin
      x_ready = 2'b00; x_cmd = 2'b00; x_rv = 2'b00; x_resp = 2'b00;
      x_code = '0; x_data = '0; x_busy = 1'b0; x_erst = 1'b1;
      w = -1; d = 0; dd = -1; legal = 0;
      if (!m_active) begin
        w = winner(req_valid, m_prio);
        if (w >= 0) x_ready = (w == 1) ? 2'b10 : 2'b01;
      end else begin
        d = cyc - m_c;
        legal = is_legal(m_e.cmd);
        dd = done_off(m_e);
        x_busy = 1'b1;
        if (legal && d == 1) x_cmd = m_e.cmd;
        if (legal && m_e.k == 0 && d == TO + 2) x_erst = 1'b0;
        if (d == dd) begin
          x_rv = m_g ? 2'b10 : 2'b01;
          x_resp = (!legal || m_e.k == 0) ? 2'b11 : m_e.eresp;
          if (legal && m_e.k != 0) begin
            x_code = m_e.ecode;
            x_data = m_e.edata;
          end
        end
      end
      chk("req_ready", {78'd0, req_ready}, {78'd0, x_ready});
      chk("busy", {79'd0, busy}, {79'd0, x_busy});
      chk("eng_command", {78'd0, eng_command}, {78'd0, x_cmd});
      chk("eng_reset", {79'd0, eng_reset}, {79'd0, x_erst});
      chk("rsp_valid", {78'd0, rsp_valid}, {78'd0, x_rv});
      chk("rsp_resp", {78'd0, rsp_resp}, {78'd0, x_resp});
      chk("rsp_code", {72'd0, rsp_code}, {72'd0, x_code});
      chk("rsp_data", rsp_data, x_data);
      chk("eng_data_in", eng_data_in, m_ldata);
      chk("eng_compressed_in", {72'd0, eng_compressed_in}, {72'd0, m_lcode});

      if (!m_active && w >= 0) begin
        m_active = 1; m_c = cyc; m_g = (w == 1);
        m_e = (w == 1) ? q1[0] : q0[0];
        m_prio = (w == 0);
        m_ldata = m_e.data; m_lcode = m_e.code;
        if (w == 1) pop1 = 1; else pop0 = 1;
      end else if (m_active && d == dd) begin
        m_active = 0;
      end
    end
  end

  // Requesters hold their heads until accepted; engine answers on the scheduled WAIT cycle.
  always @(posedge clk) begin
    int d;
    #1;
    if (pop0) begin void'(q0.pop_front()); pop0 = 0; end
    if (pop1) begin void'(q1.pop_front()); pop1 = 0; end
    req_valid = {q1.size() != 0, q0.size() != 0};
    req_cmd   = '0; req_data = '0; req_code = '0;
    if (q0.size() != 0) begin req_cmd[1:0] = q0[0].cmd; req_data[79:0] = q0[0].data; req_code[DW-1:0] = q0[0].code; end
    if (q1.size() != 0) begin req_cmd[3:2] = q1[0].cmd; req_data[159:80] = q1[0].data; req_code[2*DW-1:DW] = q1[0].code; end

    eng_response = 2'b00;
    eng_compressed_out = 8'hEE;
    eng_decompressed_out = {10{8'hDB}};
    if (m_active && is_legal(m_e.cmd)) begin
      d = cyc - m_c;
      if (m_e.k != 0 && d == 1 + m_e.k) begin
        eng_response = m_e.eresp;
        eng_compressed_out = m_e.ecode;
        eng_decompressed_out = m_e.edata;
      end else if (m_e.junk && d == 1) begin
        eng_response = 2'b01;
        eng_compressed_out = ~m_e.ecode;
      end
    end
  end

  task automatic clear_ev();
    ev_cyc.delete(); ev_g.delete(); ev_resp.delete(); ev_code.delete(); ev_data.delete(); acc_cyc.delete();
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || m_active) && n < 300);
    repeat (2) @(posedge clk);
    chk(nm, {79'd0, n < 300}, 80'd1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req_valid = '0; req_cmd = '0; req_data = '0; req_code = '0;
    eng_response = '0; eng_compressed_out = '0; eng_decompressed_out = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    chk("reset_busy", {79'd0, busy}, 80'd0);
    chk("reset_data_in", eng_data_in, 80'd0);

    // 1: single compress, answer in first WAIT cycle, junk response during ISSUE ignored
    clear_ev();
    q0.push_back(mk(2'b01, 80'h0123_4567_89AB_CDEF_0011, 8'h00, 1, 2'b01, 8'h2A, 80'h0, 1));
    wait_quiet("t1_quiet");
    chk("t1_n", ev_cyc.size(), 1);
    chk("t1_lat", ev_cyc[0] - acc_cyc[0], 3);
    chk("t1_g", {78'd0, ev_g[0]}, 80'd1);
    chk("t1_resp", {78'd0, ev_resp[0]}, 80'd1);
    chk("t1_code", {72'd0, ev_code[0]}, 80'h2A);

    // 2: both valid continuously after reset -> alternate 0,1,0,1
    apply_reset();
    clear_ev();
    q0.push_back(mk(2'b01, 80'hA0, 8'h01, 1, 2'b01, 8'h10, 80'h0, 0));
    q0.push_back(mk(2'b01, 80'hA1, 8'h02, 1, 2'b01, 8'h11, 80'h0, 0));
    q1.push_back(mk(2'b01, 80'hB0, 8'h03, 1, 2'b01, 8'h20, 80'h0, 0));
    q1.push_back(mk(2'b01, 80'hB1, 8'h04, 1, 2'b01, 8'h21, 80'h0, 0));
    wait_quiet("t2_quiet");
    chk("t2_n", ev_cyc.size(), 4);
    chk("t2_g0", {78'd0, ev_g[0]}, 80'd1);
    chk("t2_g1", {78'd0, ev_g[1]}, 80'd2);
    chk("t2_g2", {78'd0, ev_g[2]}, 80'd1);
    chk("t2_g3", {78'd0, ev_g[3]}, 80'd2);

    // 3: illegal command on req1
    clear_ev();
    q1.push_back(mk(2'b11, 80'hC0FFEE, 8'h33, 1, 2'b01, 8'h44, 80'h1, 0));
    wait_quiet("t3_quiet");
    chk("t3_lat", ev_cyc[0] - acc_cyc[0], 1);
    chk("t3_g", {78'd0, ev_g[0]}, 80'd2);
    chk("t3_resp", {78'd0, ev_resp[0]}, 80'd3);

    // 4: silent engine -> recovery, then a normal request from req1
    clear_ev();
    q0.push_back(mk(2'b10, 80'h0, 8'h05, 0, 2'b00, 8'h00, 80'h0, 0));
    wait_quiet("t4a_quiet");
    chk("t4a_lat", ev_cyc[0] - acc_cyc[0], 19);
    chk("t4a_g", {78'd0, ev_g[0]}, 80'd1);
    chk("t4a_resp", {78'd0, ev_resp[0]}, 80'd3);
    chk("t4a_data", ev_data[0], 80'd0);
    clear_ev();
    q1.push_back(mk(2'b01, 80'h77, 8'h00, 2, 2'b01, 8'h3C, 80'h0, 0));
    wait_quiet("t4b_quiet");
    chk("t4b_lat", ev_cyc[0] - acc_cyc[0], 4);
    chk("t4b_resp", {78'd0, ev_resp[0]}, 80'd1);
    chk("t4b_code", {72'd0, ev_code[0]}, 80'h3C);

    // 5: reset during WAIT abandons the transaction and restores priority to req0
    clear_ev();
    q0.push_back(mk(2'b01, 80'h55, 8'h00, 0, 2'b00, 8'h00, 80'h0, 0));
    n = 0;
    while (acc_cyc.size() == 0 && n < 50) begin @(posedge clk); n++; end
    chk("t5_accept", {79'd0, n < 50}, 80'd1);
    repeat (4) @(posedge clk);
    apply_reset();
    repeat (TO + 6) @(posedge clk);
    chk("t5_no_rsp", ev_cyc.size(), 0);
    q0.push_back(mk(2'b01, 80'h66, 8'h00, 1, 2'b01, 8'h61, 80'h0, 0));
    q1.push_back(mk(2'b01, 80'h67, 8'h00, 1, 2'b01, 8'h62, 80'h0, 0));
    wait_quiet("t5_quiet");
    chk("t5_first_g", {78'd0, ev_g[0]}, 80'd1);
    chk("t5_first_code", {72'd0, ev_code[0]}, 80'h61);

    // 6: engine error arriving in the 16th WAIT cycle beats the timeout
    clear_ev();
    q0.push_back(mk(2'b01, 80'h88, 8'h00, TO, 2'b10, 8'h09, 80'h0, 0));
    wait_quiet("t6_quiet");
    chk("t6_lat", ev_cyc[0] - acc_cyc[0], 18);
    chk("t6_resp", {78'd0, ev_resp[0]}, 80'd2);

    // 7: decompress returning plain data
    clear_ev();
    q1.push_back(mk(2'b10, 80'h0, 8'h55, 3, 2'b01, 8'h00, 80'hFEED_0000_BEEF_1234_5678, 0));
    wait_quiet("t7_quiet");
    chk("t7_lat", ev_cyc[0] - acc_cyc[0], 5);
    chk("t7_data", ev_data[0], 80'hFEED_0000_BEEF_1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
